// File: rtl/dp_pkg.sv
// Shared definitions for the dp_group controller and the dp_group/dp_unit tag decoders.
//   - ST_*       : controller state encodings
//   - DP_TAG_*   : dp_in_valid tag encodings ([0]=first/clear accumulator, [1]=last)
package dp_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [1:0] DP_TAG_MID   = 2'b00;
    localparam logic [1:0] DP_TAG_FIRST = 2'b01;
    localparam logic [1:0] DP_TAG_LAST  = 2'b10;

endpackage

// File: rtl/dp_group_ctrl_if.sv
// Bundle of job, operand, dp_group and result signals around dp_group_ctrl.
//   slave  : controller view (accepts jobs, consumes operands, drives dp_group)
//   master : environment view (scheduler, operand buffer, result consumer)
// Signals:
//   flush                        soft abort to IDLE
//   job_valid/job_ready/job_k    job request handshake and beat count
//   job_zero                     pulse when a zero-length job was discarded
//   op_valid/op_ready            operand beat handshake
//   dp_enable/dp_in_valid        dp_group enable and first/last tag
//   res_valid/res_ready          result handshake
//   busy, stall_cnt              status and stall performance counter
interface dp_group_ctrl_if #(
    parameter int unsigned KW  = 16,
    parameter int unsigned SCW = 32
) ();

    logic           flush;
    logic           job_valid;
    logic           job_ready;
    logic [KW-1:0]  job_k;
    logic           job_zero;
    logic           op_valid;
    logic           op_ready;
    logic           dp_enable;
    logic [1:0]     dp_in_valid;
    logic           res_valid;
    logic           res_ready;
    logic           busy;
    logic [SCW-1:0] stall_cnt;

    modport slave (
        input  flush, job_valid, job_k, op_valid, res_ready,
        output job_ready, job_zero, op_ready, dp_enable, dp_in_valid,
               res_valid, busy, stall_cnt
    );

    modport master (
        output flush, job_valid, job_k, op_valid, res_ready,
        input  job_ready, job_zero, op_ready, dp_enable, dp_in_valid,
               res_valid, busy, stall_cnt
    );

endinterface

// File: rtl/dp_group_ctrl.sv
// Sequencer for one dp_group dot-product array: accepts a K-beat job, streams K
// operand beats into dp_group with first/last tags, waits DP_LAT cycles for the
// pipeline to settle, then holds a result strobe until accepted.
// Ports:
//   clk    clock
//   reset  synchronous active-high reset
//   bus    dp_group_ctrl_if.slave (job, operand, dp_group, result, status signals)
// job_ready, op_ready, dp_enable and dp_in_valid are combinational from state and
// inputs; res_valid, busy, job_zero and stall_cnt are registered.
module dp_group_ctrl
    import dp_pkg::*;
#(
    parameter int unsigned KW     = 16,
    parameter int unsigned DP_LAT = 3,
    parameter int unsigned SCW    = 32
) (
    input  logic          clk,
    input  logic          reset,
    dp_group_ctrl_if.slave bus
);

    localparam int unsigned DCW = (DP_LAT > 1) ? $clog2(DP_LAT) : 1;
    localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(DP_LAT - 1);

    logic [1:0]     state_q, state_d;
    logic [KW-1:0]  rem_q, rem_d;
    logic           first_q, first_d;
    logic [DCW-1:0] drain_q, drain_d;
    logic           res_valid_q, res_valid_d;
    logic           busy_q, busy_d;
    logic           job_zero_q, job_zero_d;
    logic [SCW-1:0] stall_q, stall_d;

    logic job_ready_c;
    logic op_ready_c;
    logic beat_c;
    logic last_c;
    logic job_hs_c;

    // Handshake-side outputs; flush masks both so nothing is taken in an abort cycle.
    assign job_ready_c = (state_q == ST_IDLE) && !bus.flush;
    assign op_ready_c  = (state_q == ST_RUN) && !bus.flush;
    assign beat_c      = op_ready_c && bus.op_valid;
    assign last_c      = beat_c && (rem_q == KW'(1));
    assign job_hs_c    = job_ready_c && bus.job_valid;

    assign bus.job_ready   = job_ready_c;
    assign bus.op_ready    = op_ready_c;
    assign bus.dp_enable   = beat_c;
    assign bus.dp_in_valid = beat_c ? ((first_q ? DP_TAG_FIRST : DP_TAG_MID) |
                                       (last_c  ? DP_TAG_LAST  : DP_TAG_MID))
                                    : DP_TAG_MID;
    assign bus.res_valid   = res_valid_q;
    assign bus.busy        = busy_q;
    assign bus.job_zero    = job_zero_q;
    assign bus.stall_cnt   = stall_q;

    // Next-state and counter logic
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        first_d    = first_q;
        drain_d    = drain_q;
        stall_d    = stall_q;
        job_zero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (job_hs_c) begin
                    if (bus.job_k != '0) begin
                        rem_d   = bus.job_k;
                        first_d = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        job_zero_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (op_ready_c && !bus.op_valid && (stall_q != '1)) begin
                    stall_d = stall_q + SCW'(1);
                end
                if (beat_c) begin
                    first_d = 1'b0;
                    rem_d   = rem_q - KW'(1);
                    if (last_c) begin
                        // DRAIN covers DP_LAT-1 cycles so res_valid rises DP_LAT after the last beat
                        drain_d = DRAIN_LOAD;
                        state_d = (DRAIN_LOAD == '0) ? ST_DONE : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q - DCW'(1);
                if (drain_q <= DCW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort: drop the job, keep the stall statistics
        if (bus.flush) begin
            state_d = ST_IDLE;
            first_d = 1'b0;
            drain_d = '0;
        end
    end

    assign res_valid_d = (state_d == ST_DONE);
    assign busy_d      = (state_d != ST_IDLE);

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rem_q       <= '0;
            first_q     <= 1'b0;
            drain_q     <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            job_zero_q  <= 1'b0;
            stall_q     <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            first_q     <= first_d;
            drain_q     <= drain_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            job_zero_q  <= job_zero_d;
            stall_q     <= stall_d;
        end
    end

endmodule
